// File: rtl/sap2_computer.sv
// SAP-2-style 8-bit microcoded computer: PC, MAR, IR, A/B registers, ALU with Z/C/N
// flags, output register, internal RAM and a fixed-length fetch/execute sequencer.

module sap2_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem [0:2**ADDR_WIDTH-1];

  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

`ifndef SYNTHESIS
  task dump();
    for (int i = 0; i < 2**ADDR_WIDTH; i++)
      if (mem[i] != '0) $display("mem[%02h] = %02h", i, mem[i]);
  endtask
`endif
endmodule

module sap2_register #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [DATA_WIDTH-1:0] latched_data;

  always_ff @(posedge clk) begin
    if (reset)       latched_data <= '0;
    else if (load_i) latched_data <= data_i;
  end

  assign data_o = latched_data;
endmodule

module sap2_computer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] out_val,
  output logic                  flag_zero_o,
  output logic                  flag_carry_o,
  output logic                  flag_negative_o
);
  localparam logic [DATA_WIDTH-1:0] OP_LDA = 'h01, OP_ADD = 'h02, OP_SUB = 'h03,
                                    OP_STA = 'h04, OP_OUT = 'h05, OP_JMP = 'h06,
                                    OP_HLT = 'hFF;

  typedef enum logic [2:0] {ST_BOOT, ST_F0, ST_F1, ST_F2, ST_F3, ST_F4, ST_EXEC, ST_HALT} state_t;

  state_t                state_q, state_d;
  logic [2:0]            step_q, step_d;
  logic [ADDR_WIDTH-1:0] pc_q, mar_q;
  logic [DATA_WIDTH-1:0] ir_q, out_q;
  logic                  z_q, c_q, n_q, halt_q;
  logic                  halt;

  logic                  mar_from_pc, mar_from_mem, ir_load, pc_inc, pc_jump;
  logic                  a_load, a_src_alu, b_load, mem_we, out_load, flag_upd, halt_set;
  logic [DATA_WIDTH-1:0] a_data, b_data, ram_rdata, a_d;
  logic [DATA_WIDTH:0]   alu_res;

  function automatic logic [2:0] exec_len(input logic [DATA_WIDTH-1:0] op);
    case (op)
      OP_LDA:         return 3'd4;
      OP_ADD, OP_SUB: return 3'd6;
      OP_STA:         return 3'd3;
      default:        return 3'd1;
    endcase
  endfunction

  // Carry out of the 9-bit sum; for SUB it is the inverted borrow.
  function automatic logic [DATA_WIDTH:0] alu_f(input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b,
                                                input logic                  sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (DATA_WIDTH+1)'(1);
    return {1'b0, a} + {1'b0, b};
  endfunction

  sap2_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk), .we_i(mem_we && !reset), .addr_i(mar_q), .wdata_i(a_data), .rdata_o(ram_rdata)
  );

  sap2_register #(.DATA_WIDTH(DATA_WIDTH)) u_register_A (
    .clk(clk), .reset(reset), .load_i(a_load), .data_i(a_d), .data_o(a_data)
  );

  sap2_register #(.DATA_WIDTH(DATA_WIDTH)) u_register_B (
    .clk(clk), .reset(reset), .load_i(b_load), .data_i(ram_rdata), .data_o(b_data)
  );

  assign alu_res = alu_f(a_data, b_data, ir_q == OP_SUB);
  assign a_d     = a_src_alu ? alu_res[DATA_WIDTH-1:0] : ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // The boot state repeats the F0 transfer, giving one settle cycle after reset.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    mar_from_pc  = 1'b0;
    mar_from_mem = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_jump      = 1'b0;
    a_load       = 1'b0;
    a_src_alu    = 1'b0;
    b_load       = 1'b0;
    mem_we       = 1'b0;
    out_load     = 1'b0;
    flag_upd     = 1'b0;
    halt_set     = 1'b0;
    case (state_q)
      ST_BOOT: begin mar_from_pc = 1'b1; state_d = ST_F0; end
      ST_F0:   begin mar_from_pc = 1'b1; state_d = ST_F1; end
      ST_F1:   begin ir_load = 1'b1; pc_inc = 1'b1; state_d = ST_F2; end
      ST_F2:   begin mar_from_pc = 1'b1; state_d = ST_F3; end
      ST_F3:   begin mar_from_mem = 1'b1; pc_inc = 1'b1; state_d = ST_F4; end
      ST_F4:   begin state_d = ST_EXEC; step_d = 3'd1; end
      ST_EXEC: begin
        case (ir_q)
          OP_LDA: if (step_q == 3'd4) begin a_load = 1'b1; flag_upd = 1'b1; end
          OP_ADD, OP_SUB: begin
            b_load = (step_q == 3'd2);
            if (step_q == 3'd6) begin a_load = 1'b1; a_src_alu = 1'b1; flag_upd = 1'b1; end
          end
          OP_STA:  mem_we   = (step_q == 3'd3);
          OP_OUT:  out_load = 1'b1;
          OP_JMP:  pc_jump  = 1'b1;
          OP_HLT:  halt_set = 1'b1;
          default: ;
        endcase
        if (ir_q == OP_HLT)                 state_d = ST_HALT;
        else if (step_q == exec_len(ir_q)) state_d = ST_F0;
        else                                step_d  = step_q + 3'd1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_F0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      mar_q  <= '0;
      ir_q   <= '0;
      out_q  <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      n_q    <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      if (mar_from_pc)       mar_q <= pc_q;
      else if (mar_from_mem) mar_q <= ADDR_WIDTH'(ram_rdata);
      if (ir_load)           ir_q  <= ram_rdata;
      if (pc_jump)           pc_q  <= mar_q;
      else if (pc_inc)       pc_q  <= pc_q + ADDR_WIDTH'(1);
      if (out_load)          out_q <= a_data;
      if (flag_upd) begin
        z_q <= (a_d == '0);
        n_q <= a_d[DATA_WIDTH-1];
        if (a_src_alu) c_q <= alu_res[DATA_WIDTH];
      end
      if (halt_set)          halt_q <= 1'b1;
    end
  end

  assign halt            = halt_q;
  assign out_val         = out_q;
  assign flag_zero_o     = z_q;
  assign flag_carry_o    = c_q;
  assign flag_negative_o = n_q;
endmodule

// File: tb/tb_sap2_computer.sv
// Scoreboard bench for sap2_computer: expectations are queued per clock edge and
// compared when that edge arrives.

module tb_sap2_computer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] out_val;
  logic       flag_zero_o, flag_carry_o, flag_negative_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         edge_n;
    int         sel;
    logic [7:0] val;
    string      name;
  } exp_t;
  exp_t sbq[$];
  exp_t it;

  sap2_computer #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .out_val(out_val), .flag_zero_o(flag_zero_o),
    .flag_carry_o(flag_carry_o), .flag_negative_o(flag_negative_o)
  );

  always #5 clk = ~clk;

  localparam int S_A = 0, S_B = 1, S_Z = 2, S_C = 3, S_N = 4, S_OUT = 5, S_HLT = 6,
                 S_PC = 7, S_M20 = 8;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      S_A:     return dut.u_register_A.latched_data;
      S_B:     return dut.u_register_B.latched_data;
      S_Z:     return {7'b0, flag_zero_o};
      S_C:     return {7'b0, flag_carry_o};
      S_N:     return {7'b0, flag_negative_o};
      S_OUT:   return out_val;
      S_HLT:   return {7'b0, dut.halt};
      S_PC:    return dut.pc_q;
      S_M20:   return dut.u_ram.mem[8'h20];
      default: return 8'h00;
    endcase
  endfunction

  function automatic void push(input int e, input int sel, input logic [7:0] v, input string nm);
    exp_t x;
    x.edge_n = e; x.sel = sel; x.val = v; x.name = nm;
    sbq.push_back(x);
  endfunction

  task automatic begin_reset();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) dut.u_ram.mem[i] = 8'h00;
  endtask

  task automatic end_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load_lda_add_prog();
    dut.u_ram.mem[0] = 8'h01; dut.u_ram.mem[1] = 8'h10;
    dut.u_ram.mem[2] = 8'h02; dut.u_ram.mem[3] = 8'h11;
    dut.u_ram.mem[4] = 8'hFF; dut.u_ram.mem[5] = 8'h00;
    dut.u_ram.mem[8'h10] = 8'hFF; dut.u_ram.mem[8'h11] = 8'h01;
  endtask

  task automatic test_reset();
    begin_reset();
    end_reset();
    push(0, S_A, 8'h00, "rst_A");   push(0, S_B, 8'h00, "rst_B");
    push(0, S_Z, 8'h00, "rst_Z");   push(0, S_C, 8'h00, "rst_C");
    push(0, S_N, 8'h00, "rst_N");   push(0, S_OUT, 8'h00, "rst_out");
    push(0, S_HLT, 8'h00, "rst_halt"); push(0, S_PC, 8'h00, "rst_PC");
    while (sbq.size() > 0 && sbq[0].edge_n == 0) begin
      it = sbq.pop_front(); total++;
      if (obs(it.sel) !== it.val) begin
        bad++; $display("FAIL %s: got %02h expected %02h", it.name, obs(it.sel), it.val);
      end
    end
  endtask

  task automatic test_lda_add();
    int n;
    begin_reset();
    load_lda_add_prog();
    end_reset();
    push(0, S_A, 8'h00, "la_A0");   push(9, S_A, 8'h00, "la_A9");
    push(10, S_A, 8'hFF, "la_A10"); push(10, S_N, 8'h01, "la_N10");
    push(10, S_Z, 8'h00, "la_Z10"); push(20, S_A, 8'hFF, "la_A20");
    push(21, S_A, 8'h00, "la_A21"); push(21, S_B, 8'h01, "la_B21");
    push(21, S_Z, 8'h01, "la_Z21"); push(21, S_C, 8'h01, "la_C21");
    push(21, S_N, 8'h00, "la_N21");
    for (int e = 0; e <= 21; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      while (sbq.size() > 0 && sbq[0].edge_n == e) begin
        it = sbq.pop_front(); total++;
        if (obs(it.sel) !== it.val) begin
          bad++; $display("FAIL %s: got %02h expected %02h", it.name, obs(it.sel), it.val);
        end
      end
    end
    n = 0;
    while (dut.halt !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (dut.halt !== 1'b1) begin bad++; $display("FAIL la_halt: got %b expected 1", dut.halt); end
    repeat (10) @(posedge clk);
    #1; total++;
    if (obs(S_A) !== 8'h00 || obs(S_PC) !== 8'h06) begin
      bad++; $display("FAIL la_frozen: got A=%02h PC=%02h expected A=00 PC=06", obs(S_A), obs(S_PC));
    end
  endtask

  task automatic test_sub_pos();
    int n;
    begin_reset();
    dut.u_ram.mem[0] = 8'h01; dut.u_ram.mem[1] = 8'h10;
    dut.u_ram.mem[2] = 8'h03; dut.u_ram.mem[3] = 8'h11;
    dut.u_ram.mem[4] = 8'h05; dut.u_ram.mem[6] = 8'hFF;
    dut.u_ram.mem[8'h10] = 8'h05; dut.u_ram.mem[8'h11] = 8'h03;
    end_reset();
    push(21, S_A, 8'h02, "sp_A");  push(21, S_C, 8'h01, "sp_C");
    push(21, S_Z, 8'h00, "sp_Z");  push(21, S_N, 8'h00, "sp_N");
    push(26, S_OUT, 8'h00, "sp_out26"); push(27, S_OUT, 8'h02, "sp_out27");
    for (int e = 0; e <= 27; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      while (sbq.size() > 0 && sbq[0].edge_n == e) begin
        it = sbq.pop_front(); total++;
        if (obs(it.sel) !== it.val) begin
          bad++; $display("FAIL %s: got %02h expected %02h", it.name, obs(it.sel), it.val);
        end
      end
    end
    n = 0;
    while (dut.halt !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (dut.halt !== 1'b1) begin bad++; $display("FAIL sp_halt: got %b expected 1", dut.halt); end
  endtask

  task automatic test_sub_neg();
    begin_reset();
    dut.u_ram.mem[0] = 8'h01; dut.u_ram.mem[1] = 8'h10;
    dut.u_ram.mem[2] = 8'h03; dut.u_ram.mem[3] = 8'h11;
    dut.u_ram.mem[4] = 8'hFF;
    dut.u_ram.mem[8'h10] = 8'h03; dut.u_ram.mem[8'h11] = 8'h05;
    end_reset();
    push(21, S_A, 8'hFE, "sn_A");  push(21, S_C, 8'h00, "sn_C");
    push(21, S_N, 8'h01, "sn_N");  push(21, S_Z, 8'h00, "sn_Z");
    for (int e = 0; e <= 21; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      while (sbq.size() > 0 && sbq[0].edge_n == e) begin
        it = sbq.pop_front(); total++;
        if (obs(it.sel) !== it.val) begin
          bad++; $display("FAIL %s: got %02h expected %02h", it.name, obs(it.sel), it.val);
        end
      end
    end
  endtask

  task automatic test_sta_jmp();
    int n;
    begin_reset();
    dut.u_ram.mem[0] = 8'h01; dut.u_ram.mem[1] = 8'h10;
    dut.u_ram.mem[2] = 8'h04; dut.u_ram.mem[3] = 8'h20;
    dut.u_ram.mem[4] = 8'h06; dut.u_ram.mem[5] = 8'h08;
    dut.u_ram.mem[8] = 8'hFF; dut.u_ram.mem[8'h10] = 8'h5A;
    end_reset();
    push(17, S_M20, 8'h00, "sj_m20_17"); push(18, S_M20, 8'h5A, "sj_m20_18");
    push(24, S_PC, 8'h08, "sj_PC24");
    for (int e = 0; e <= 24; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      while (sbq.size() > 0 && sbq[0].edge_n == e) begin
        it = sbq.pop_front(); total++;
        if (obs(it.sel) !== it.val) begin
          bad++; $display("FAIL %s: got %02h expected %02h", it.name, obs(it.sel), it.val);
        end
      end
    end
    n = 0;
    while (dut.halt !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (dut.halt !== 1'b1) begin bad++; $display("FAIL sj_halt: got %b expected 1", dut.halt); end
    repeat (8) @(posedge clk);
    #1; total++;
    if (obs(S_PC) !== 8'h0A || obs(S_M20) !== 8'h5A || obs(S_A) !== 8'h5A) begin
      bad++; $display("FAIL sj_after_halt: got PC=%02h m20=%02h A=%02h expected 0A 5A 5A",
                      obs(S_PC), obs(S_M20), obs(S_A));
    end
  endtask

  task automatic test_reset_mid_add();
    int n;
    begin_reset();
    load_lda_add_prog();
    end_reset();
    push(10, S_A, 8'hFF, "rm_A10"); push(17, S_B, 8'h01, "rm_B17");
    for (int e = 0; e <= 18; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      while (sbq.size() > 0 && sbq[0].edge_n == e) begin
        it = sbq.pop_front(); total++;
        if (obs(it.sel) !== it.val) begin
          bad++; $display("FAIL %s: got %02h expected %02h", it.name, obs(it.sel), it.val);
        end
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    push(0, S_A, 8'h00, "rm_rA");  push(0, S_B, 8'h00, "rm_rB");
    push(0, S_N, 8'h00, "rm_rN");  push(0, S_PC, 8'h00, "rm_rPC");
    push(10, S_A, 8'hFF, "rm2_A10"); push(10, S_N, 8'h01, "rm2_N10");
    push(21, S_A, 8'h00, "rm2_A21"); push(21, S_B, 8'h01, "rm2_B21");
    push(21, S_Z, 8'h01, "rm2_Z21"); push(21, S_C, 8'h01, "rm2_C21");
    for (int e = 0; e <= 21; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      while (sbq.size() > 0 && sbq[0].edge_n == e) begin
        it = sbq.pop_front(); total++;
        if (obs(it.sel) !== it.val) begin
          bad++; $display("FAIL %s: got %02h expected %02h", it.name, obs(it.sel), it.val);
        end
      end
    end
    n = 0;
    while (dut.halt !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (dut.halt !== 1'b1) begin bad++; $display("FAIL rm_halt: got %b expected 1", dut.halt); end
  endtask

  task automatic test_unknown_opcode();
    int n;
    begin_reset();
    dut.u_ram.mem[0] = 8'h01; dut.u_ram.mem[1] = 8'h10;
    dut.u_ram.mem[2] = 8'h7E; dut.u_ram.mem[3] = 8'h00;
    dut.u_ram.mem[4] = 8'hFF; dut.u_ram.mem[8'h10] = 8'h80;
    end_reset();
    push(10, S_A, 8'h80, "uk_A10");
    push(16, S_A, 8'h80, "uk_A16");  push(16, S_B, 8'h00, "uk_B16");
    push(16, S_N, 8'h01, "uk_N16");  push(16, S_Z, 8'h00, "uk_Z16");
    push(16, S_C, 8'h00, "uk_C16");  push(16, S_OUT, 8'h00, "uk_out16");
    push(16, S_PC, 8'h04, "uk_PC16"); push(16, S_HLT, 8'h00, "uk_halt16");
    for (int e = 0; e <= 16; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      while (sbq.size() > 0 && sbq[0].edge_n == e) begin
        it = sbq.pop_front(); total++;
        if (obs(it.sel) !== it.val) begin
          bad++; $display("FAIL %s: got %02h expected %02h", it.name, obs(it.sel), it.val);
        end
      end
    end
    n = 0;
    while (dut.halt !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (dut.halt !== 1'b1 || obs(S_PC) !== 8'h06 || obs(S_A) !== 8'h80) begin
      bad++; $display("FAIL uk_halt: got halt=%b PC=%02h A=%02h expected 1 06 80",
                      dut.halt, obs(S_PC), obs(S_A));
    end
  endtask

  initial begin
    test_reset();
    test_lda_add();
    test_sub_pos();
    test_sub_neg();
    test_sta_jmp();
    test_reset_mid_add();
    test_unknown_opcode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
